// File: rtl/ahb_bram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_bram_ctrl_if
// AHB-Lite slave-side signal bundle for ahb_bram_ctrl.
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA : address/data from the master
//   HREADY                                     : bus-wide ready (from the interconnect)
//   HREADYOUT, HRDATA, HRESP                   : slave response (HRESP 0=OKAY, 1=ERROR)
// ---------------------------------------------------------------------------
interface ahb_bram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_bram_ctrl
// AHB-Lite slave bridging to a simple dual-port block RAM (port A write,
// port B read with one cycle registered latency). Zero-wait reads and
// writes, byte/halfword/word writes via byte enables, read-after-write
// forwarding, and a two-cycle ERROR response for misaligned transfers.
//
// Ports
//   clka   : single clock for bus and RAM
//   rst    : synchronous active-high reset
//   ahb    : AHB-Lite slave signals (ahb_bram_ctrl_if.slave)
//   addra  : RAM write word address        dina : RAM write data
//   wea    : RAM byte write enables        addrb: RAM read word address
//   doutb  : RAM read data, one cycle after addrb
// ---------------------------------------------------------------------------
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clka,
    input  logic                  rst,
    ahb_bram_ctrl_if.slave        ahb,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);

    typedef enum logic [1:0] {OKAY, ERR1, ERR2} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            3'd0:    m = 4'b0001 << a;
            3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = a[0];
            3'd2:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t                state;
    logic                  hreadyout_q;
    logic                  hresp_q;

    logic                  accept;
    logic                  mis;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  err_acc;
    logic                  raw_hit;
    logic [ADDR_WIDTH-1:0] waddr;

    logic                  wr_vld_p0;
    logic [ADDR_WIDTH-1:0] wr_addr_p0;
    logic [3:0]            wr_mask_p0;

    logic                  fwd_vld_p0;
    logic [3:0]            fwd_mask_p0;
    logic [31:0]           fwd_data_p0;

    // Upper address bits and HTRANS[0] (NONSEQ vs SEQ) do not affect behaviour.
    logic                  unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    // ---- address phase decode ----
    assign accept  = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign waddr   = ahb.HADDR[ADDR_WIDTH+1:2];
    assign mis     = misaligned(ahb.HSIZE, ahb.HADDR[1:0]);
    assign wr_acc  = accept & ~mis &  ahb.HWRITE;
    assign rd_acc  = accept & ~mis & ~ahb.HWRITE;
    assign err_acc = accept & mis;

    // A read whose address phase overlaps the data phase of a write to the
    // same word would see stale RAM data next cycle, so capture the write.
    assign raw_hit = rd_acc & wr_vld_p0 & (waddr == wr_addr_p0);

    assign addrb = waddr;

    // ---- control registers and error FSM ----
    always_ff @(posedge clka) begin
        if (rst) begin
            state       <= OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            wr_vld_p0   <= 1'b0;
            wr_mask_p0  <= 4'b0000;
            fwd_vld_p0  <= 1'b0;
            fwd_mask_p0 <= 4'b0000;
        end else begin
            wr_vld_p0  <= wr_acc;
            fwd_vld_p0 <= raw_hit;
            if (wr_acc)
                wr_mask_p0 <= lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
            if (raw_hit)
                fwd_mask_p0 <= wr_mask_p0;

            case (state)
                ERR1: begin
                    state       <= ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                OKAY, ERR2: begin
                    if (err_acc) begin
                        state       <= ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state       <= OKAY;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                default: begin
                    state       <= OKAY;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    // ---- data registers (no reset; qualified by the valid flags above) ----
    always_ff @(posedge clka) begin
        if (wr_acc)
            wr_addr_p0 <= waddr;
        if (raw_hit)
            fwd_data_p0 <= ahb.HWDATA;
    end

    // ---- data phase: RAM write port and read merge ----
    assign addra = wr_addr_p0;
    assign dina  = ahb.HWDATA;
    // Reset kills a write whose data phase coincides with it.
    assign wea   = (wr_vld_p0 & ~rst) ? wr_mask_p0 : 4'b0000;

    always_comb begin
        ahb.HRDATA = doutb;
        for (int i = 0; i < 4; i++) begin
            if (fwd_vld_p0 && fwd_mask_p0[i])
                ahb.HRDATA[8*i +: 8] = fwd_data_p0[8*i +: 8];
        end
    end

    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = hresp_q;

endmodule

// File: doc/ahb_bram_ctrl.md
AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, giving the RAM word-address width (2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have port clka, input, 1: single clock for the bus side and the RAM side.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HTRANS 2, HSIZE 3, HWRITE 1, HWDATA 32, HREADY 1.
REQ-005 SHALL have AHB-Lite slave outputs: HREADYOUT 1, HRDATA 32, HRESP 1 (0 = OKAY, 1 = ERROR).
REQ-006 SHALL have RAM-side ports: addra out ADDR_WIDTH, dina out 32, wea out 4 (byte enables, bit n = byte lane n), addrb out ADDR_WIDTH, doutb in 32. doutb is the registered read data, one cycle after addrb.

Function
REQ-007 SHALL accept a transfer when HSEL & HTRANS[1] & HREADY is high at a rising edge (NONSEQ or SEQ). IDLE and BUSY SHALL get a zero-wait OKAY response and have no side effects.
REQ-008 SHALL take the word address from HADDR[ADDR_WIDTH+1:2]. Upper address bits SHALL be ignored.
REQ-009 SHALL derive the byte mask as follows:
- HSIZE=0: lane HADDR[1:0].
- HSIZE=1: lanes 1:0 when HADDR[1]=0, lanes 3:2 when HADDR[1]=1.
- HSIZE=2: all four lanes.
REQ-010 SHALL classify a transfer as misaligned when any of these holds: HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0; HSIZE>2.
REQ-011 SHALL drive addrb combinationally from the HADDR word address in every cycle.
REQ-012 Reads SHALL complete with zero wait states: in the data phase, HRDATA equals doutb (after forwarding per REQ-016), with HREADYOUT=1 and HRESP=0.
REQ-013 Writes SHALL register the word address and byte mask in the address phase.
REQ-014 In the write data phase: addra = registered address, wea = registered mask, dina = HWDATA. The RAM commits at the end of that cycle, and HREADYOUT=1.
REQ-015 wea SHALL be 4'b0000 in every cycle that is not an accepted, aligned write data phase.
REQ-016 Read-after-write hazard: when a read address phase coincides with a write data phase to the same word, the controller SHALL register HWDATA and the write mask. In the read data phase, each masked byte of HRDATA SHALL come from the registered HWDATA; the other bytes come from doutb.
REQ-017 A read to a different word, or a write following a write, SHALL NOT trigger forwarding.
REQ-018 Misaligned transfers SHALL produce a two-cycle ERROR response through an FSM with states OKAY, ERR1 and ERR2:
- OKAY -> ERR1 on acceptance of a misaligned transfer.
- ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Goes to OKAY, or back to ERR1 if another misaligned transfer is accepted in that cycle.
REQ-019 A misaligned write SHALL NOT assert wea. A misaligned read SHALL NOT arm forwarding.
REQ-020 A transfer accepted in ERR2 SHALL be processed normally: its address phase is the ERR2 cycle.
REQ-021 HRDATA SHALL be don't-care (driven as doutb) outside read data phases.
REQ-022 Back-to-back transfers of any mix (read, write, aligned, misaligned) SHALL be sustained at one per cycle, except for the error stall cycle.

Reset
REQ-023 While rst is high at a clock edge, the FSM SHALL go to OKAY. Pending write and forwarding registers SHALL clear.
REQ-024 Outputs after reset SHALL be: HREADYOUT=1, HRESP=0, wea=0.
REQ-025 wea SHALL be forced to 0 in any cycle where rst=1. A write whose data phase coincides with reset SHALL be discarded.
REQ-026 A transfer in progress when reset asserts SHALL be abandoned with no RAM write and no error response.

Verification
REQ-027 Word write then read: write 0xDEADBEEF to 0x0000_0010, then idle, then read 0x10 -> wea=4'hF, addra=4 in the data phase; read returns 0xDEADBEEF, zero waits, HRESP=0.
REQ-028 Byte and halfword writes: word 0x20 = 0x00000000; write byte 0xAA to 0x21, then halfword 0x1234 to 0x22 -> wea=4'h2 then 4'hC; a later read returns 0x1234AA00.
REQ-029 Hazard: word 0x30 = 0x11111111; write byte 0x55 to 0x30, immediately followed by a read of 0x30 -> HRDATA=0x11111155 in the next cycle. A read of 0x34 in the same slot SHALL return the RAM content unmodified.
REQ-030 Misaligned: word write to 0x42 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles; wea stays 0; the RAM at 0x40 is unchanged. HSIZE=3 gives the same result.
REQ-031 Reset mid-write: write address phase to 0x50, then rst=1 during the data phase -> wea=0, the word at 0x50 is unchanged, and after reset HREADYOUT=1, HRESP=0.
REQ-032 Streaming: 16 back-to-back SEQ word writes followed by 16 reads over 0x100-0x13C -> all data matches with no wait states and 32 cycles total.
